// File: rtl/alu_req_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters: arbitrate, issue, return result.
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module alu_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int SEL_W   = 4,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [SEL_W-1:0]          alu_sel,
   input  logic [DATA_W-1:0]         alu_out,
   input  logic                      alu_carry,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_carry,
   output logic                      busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [ID_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_carry_q, rsp_carry_d;

   logic              any_req;
   logic [ID_W-1:0]   win;

   // Later loop iterations overwrite earlier ones, so the last hit is the highest-priority candidate.
   always_comb begin
      int cand;
      cand    = 0;
      any_req = |req_valid;
      win     = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) win = ID_W'(i);
      end
`else
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = (int'(last_q) + k) % NUM_REQ;
         if (req_valid[cand]) win = ID_W'(cand);
      end
`endif
   end

   always_comb begin
      req_ready = '0;
      if (state_q == ST_IDLE && any_req) req_ready[win] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      idx_d       = idx_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_carry_d = rsp_carry_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               alu_a_d   = req_a[int'(win)*DATA_W +: DATA_W];
               alu_b_d   = req_b[int'(win)*DATA_W +: DATA_W];
               alu_sel_d = req_sel[int'(win)*SEL_W +: SEL_W];
               idx_d     = win;
               last_d    = win;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_data_d  = alu_out;
            rsp_carry_d = alu_carry;
            rsp_id_d    = idx_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         last_q      <= ID_W'(NUM_REQ - 1);
         idx_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         idx_q       <= idx_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_carry_q <= rsp_carry_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_carry = rsp_carry_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed table, multi-cycle corner sequences, random traffic vs. a model.
// Valid/ready: a transfer happens at a rising edge where both valid and ready are high.
module tb_alu_req_arbiter;

   localparam int NR = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req_valid;
   logic [NR-1:0] req_ready;
   logic [NR*8-1:0] req_a, req_b;
   logic [NR*4-1:0] req_sel;
   logic [7:0]    alu_a, alu_b, alu_out;
   logic [3:0]    alu_sel;
   logic          alu_carry;
   logic          rsp_valid, rsp_ready, rsp_carry, busy;
   logic [1:0]    rsp_id;
   logic [7:0]    rsp_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_req_arbiter #(.NUM_REQ(NR), .DATA_W(8), .SEL_W(4), .ID_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
      .busy(busy)
   );

   // External ALU: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor, else pass A.
   function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
      case (s)
         4'd0:    return {1'b0, a} + {1'b0, b};
         4'd1:    return {1'b0, a} - {1'b0, b};
         4'd2:    return {1'b0, a & b};
         4'd3:    return {1'b0, a | b};
         4'd4:    return {1'b0, a ^ b};
         default: return {1'b0, a};
      endcase
   endfunction

   assign {alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_sel);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
      req_valid[i]        = 1'b1;
      req_a[i*8 +: 8]     = a;
      req_b[i*8 +: 8]     = b;
      req_sel[i*4 +: 4]   = s;
   endtask

   task automatic do_single(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                            input logic [7:0] ed, input logic ec, input string tag);
      logic [NR-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      req_valid = '0;
      set_req(idx, a, b, s);
      #1;
      check({tag, " req_ready"}, 32'(req_ready), 32'(oh));
      tick();
      req_valid = '0;
      #1;
      check({tag, " exec busy"}, 32'(busy), 1);
      check({tag, " exec rsp_valid"}, 32'(rsp_valid), 0);
      check({tag, " exec req_ready"}, 32'(req_ready), 0);
      check({tag, " alu_a"}, 32'(alu_a), 32'(a));
      check({tag, " alu_b"}, 32'(alu_b), 32'(b));
      tick();
      check({tag, " rsp_valid"}, 32'(rsp_valid), 1);
      check({tag, " rsp_id"}, 32'(rsp_id), 32'(idx));
      check({tag, " rsp_data"}, 32'(rsp_data), 32'(ed));
      check({tag, " rsp_carry"}, 32'(rsp_carry), 32'(ec));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, " done rsp_valid"}, 32'(rsp_valid), 0);
      check({tag, " done busy"}, 32'(busy), 0);
   endtask

   typedef struct {
      int         idx;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] sel;
      logic [7:0] ed;
      logic       ec;
   } vec_t;

   vec_t vecs[8];

   logic [10:0] exp_q[$];

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int grants[5];
      int ng;
      int last_m;
      int phase;
      int w;
      int prev_w;
      logic [NR-1:0] exp_ready;
      logic [8:0]  r;
      logic [10:0] got, expv;
      logic [7:0]  bp_data;

      vecs[0] = '{0, 8'h12, 8'h34, 4'd0, 8'h46, 1'b0};
      vecs[1] = '{2, 8'hF0, 8'h20, 4'd0, 8'h10, 1'b1};
      vecs[2] = '{1, 8'hFF, 8'h01, 4'd0, 8'h00, 1'b1};
      vecs[3] = '{3, 8'h10, 8'h20, 4'd1, 8'hF0, 1'b1};
      vecs[4] = '{3, 8'h20, 8'h10, 4'd1, 8'h10, 1'b0};
      vecs[5] = '{1, 8'hF0, 8'h3C, 4'd2, 8'h30, 1'b0};
      vecs[6] = '{2, 8'hF0, 8'h0F, 4'd3, 8'hFF, 1'b0};
      vecs[7] = '{0, 8'hAA, 8'hFF, 4'd4, 8'h55, 1'b0};

      // Clock/reset
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
      tick();
      tick();
      check("rst rsp_valid", 32'(rsp_valid), 0);
      check("rst busy", 32'(busy), 0);
      check("rst rsp_id", 32'(rsp_id), 0);
      check("rst rsp_data", 32'(rsp_data), 0);
      check("rst rsp_carry", 32'(rsp_carry), 0);
      check("rst alu_a", 32'(alu_a), 0);
      check("rst alu_b", 32'(alu_b), 0);
      check("rst alu_sel", 32'(alu_sel), 0);
      check("rst req_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      tick();

      // Table-driven single-requester operations
      for (int i = 0; i < 8; i++)
         do_single(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].ed, vecs[i].ec,
                   $sformatf("vec%0d", i));

      // Idle: nothing requested for 10 cycles
      for (int i = 0; i < 10; i++) begin
         check("idle req_ready", 32'(req_ready), 0);
         check("idle rsp_valid", 32'(rsp_valid), 0);
         check("idle busy", 32'(busy), 0);
         tick();
      end

      // Backpressure: response held for 5 cycles while everyone requests
      req_valid = '0;
      set_req(1, 8'h03, 8'h04, 4'd0);
      tick();
      req_valid = '0;
      tick();
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      bp_data = 8'h07;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp rsp_valid", 32'(rsp_valid), 1);
         check("bp rsp_id", 32'(rsp_id), 1);
         check("bp rsp_data", 32'(rsp_data), 32'(bp_data));
         check("bp busy", 32'(busy), 1);
         check("bp req_ready", 32'(req_ready), 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp released rsp_valid", 32'(rsp_valid), 0);
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("bp next grant", 32'(req_ready), 32'h1);
`else
      check("bp next grant", 32'(req_ready), 32'h4);
`endif
      tick();
      req_valid = '0;
      tick();
      tick();
      check("bp drained busy", 32'(busy), 0);

      // Reset during EXEC discards the operation
      rsp_ready = 1'b0;
      set_req(2, 8'h55, 8'h11, 4'd0);
      tick();
      req_valid = '0;
      rst_n = 1'b0;
      tick();
      check("midrst rsp_valid", 32'(rsp_valid), 0);
      check("midrst busy", 32'(busy), 0);
      rst_n = 1'b1;

      // Grant order with all requesters held valid
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      ng = 0;
      for (int cyc = 0; cyc < 40 && ng < 5; cyc++) begin
         #1;
         if (req_ready != '0) begin
            for (int j = 0; j < NR; j++) if (req_ready[j]) grants[ng] = j;
            ng++;
         end
         tick();
      end
      req_valid = '0;
      check("rr grant count", 32'(ng), 5);
      for (int i = 0; i < 5; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         check($sformatf("prio grant%0d", i), 32'(grants[i]), 0);
`else
         check($sformatf("rr grant%0d", i), 32'(grants[i]), 32'(i % NR));
`endif
      end
      tick();
      tick();
      tick();

      // Random traffic against a transaction-level model
      rst_n = 1'b0;
      rsp_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      last_m = NR - 1;
      phase  = 0;
      prev_w = -1;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (prev_w >= 0) req_valid[prev_w] = 1'b0;
         for (int i = 0; i < NR; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
               set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 5)));
         rsp_ready = 1'($urandom_range(0, 1));
         #1;
         w = -1;
         exp_ready = '0;
         if (phase == 0 && req_valid != '0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            for (int k = NR - 1; k >= 0; k--) if (req_valid[k]) w = k;
`else
            for (int k = 1; k <= NR && w < 0; k++)
               if (req_valid[(last_m + k) % NR]) w = (last_m + k) % NR;
`endif
            exp_ready[w] = 1'b1;
         end
         check("rand req_ready", 32'(req_ready), 32'(exp_ready));
         check("rand rsp_valid", 32'(rsp_valid), 32'(phase == 2));
         if (rsp_valid && rsp_ready) begin
            got = {rsp_id, rsp_carry, rsp_data};
            if (exp_q.size() == 0) check("rand unexpected rsp", 32'(got), 32'h7FF);
            else begin
               expv = exp_q.pop_front();
               check("rand rsp", 32'(got), 32'(expv));
            end
         end
         case (phase)
            0: if (w >= 0) begin
                  r = alu_f(req_a[w*8 +: 8], req_b[w*8 +: 8], req_sel[w*4 +: 4]);
                  exp_q.push_back({2'(w), r});
                  last_m = w;
                  phase  = 1;
               end
            1: phase = 2;
            default: if (rsp_ready) phase = 0;
         endcase
         prev_w = w;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
